// File: rtl/lcd_read_enable_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_read_enable_if
// Description : Signal bundle between the LCD controller FSM and the HD44780
//               read-cycle generator.
//                 iStartRead          - request a read cycle
//                 iRegisterSelect     - RS value for the read
//                 iLCD_Data[3:0]      - LCD data pins SF_D[11:8]
//                 oLCD_Enabled        - LCD E pin
//                 oLCD_ReadWrite      - LCD RW pin (1 = read)
//                 oLCD_RegisterSelect - LCD RS pin
//                 oBusRelease         - 1 = FPGA must tristate SF_D
//                 oData[7:0]          - assembled byte {upper, lower}
//                 oBusyFlag           - oData[7] when last read had RS = 0
//                 oReadDone           - one-cycle pulse, oData valid
//               slave  : the read-cycle generator
//               master : the controller / pins side
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_read_enable_if;
    logic       iStartRead;
    logic       iRegisterSelect;
    logic [3:0] iLCD_Data;
    logic       oLCD_Enabled;
    logic       oLCD_ReadWrite;
    logic       oLCD_RegisterSelect;
    logic       oBusRelease;
    logic [7:0] oData;
    logic       oBusyFlag;
    logic       oReadDone;

    modport slave (
        input  iStartRead, iRegisterSelect, iLCD_Data,
        output oLCD_Enabled, oLCD_ReadWrite, oLCD_RegisterSelect,
               oBusRelease, oData, oBusyFlag, oReadDone
    );

    modport master (
        output iStartRead, iRegisterSelect, iLCD_Data,
        input  oLCD_Enabled, oLCD_ReadWrite, oLCD_RegisterSelect,
               oBusRelease, oData, oBusyFlag, oReadDone
    );
endinterface
`default_nettype wire

// File: rtl/lcd_read_enable.sv
`default_nettype none
// ============================================================================
// Module      : lcd_read_enable
// Description : HD44780 4-bit read-cycle generator for the Spartan-3E
//               character LCD. Drives RS, RW=1 and two E pulses, samples the
//               upper then lower nibble and presents the assembled byte.
//               Ports:
//                 Clock  - 50 MHz system clock
//                 iReset - asynchronous active-high reset
//                 bus    - lcd_read_enable_if.slave (see interface header)
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_read_enable #(
    parameter int SETUP_CYCLES = 3,
    parameter int EHIGH_CYCLES = 13,
    parameter int GAP_CYCLES   = 50,
    parameter int HOLD_CYCLES  = 2,
    parameter int CNT_W        = 16
) (
    input  wire logic         Clock,
    input  wire logic         iReset,
    lcd_read_enable_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETUP    = 3'd1,
        S_EHIGH_UP = 3'd2,
        S_GAP      = 3'd3,
        S_EHIGH_LO = 3'd4,
        S_HOLD     = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    // Terminal counts: each state exits when the counter reaches N-1.
    localparam logic [CNT_W-1:0] C_SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_EHIGH_LAST = CNT_W'(EHIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               e_q,     e_d;
    logic               rw_q,    rw_d;
    logic               rs_q,    rs_d;
    logic               rel_q,   rel_d;
    logic               done_q,  done_d;
    logic               busy_q,  busy_d;
    logic [7:0]         data_q,  data_d;

    always_ff @(posedge Clock or posedge iReset) begin
        if (iReset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            e_q     <= 1'b0;
            rw_q    <= 1'b0;
            rs_q    <= 1'b0;
            rel_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            rw_q    <= rw_d;
            rs_q    <= rs_d;
            rel_q   <= rel_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        e_d     = e_q;
        rw_d    = rw_q;
        rs_d    = rs_q;
        rel_d   = rel_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        data_d  = data_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.iStartRead) begin
                    state_d = S_SETUP;
                    rs_d    = bus.iRegisterSelect;
                    rw_d    = 1'b1;
                    rel_d   = 1'b1;
                end
            end
            S_SETUP: begin
                if (cnt_q == C_SETUP_LAST) begin
                    state_d = S_EHIGH_UP;
                    cnt_d   = '0;
                    e_d     = 1'b1;
                end
            end
            S_EHIGH_UP: begin
                if (cnt_q == C_EHIGH_LAST) begin
                    state_d     = S_GAP;
                    cnt_d       = '0;
                    e_d         = 1'b0;
                    data_d[7:4] = bus.iLCD_Data;
                end
            end
            S_GAP: begin
                if (cnt_q == C_GAP_LAST) begin
                    state_d = S_EHIGH_LO;
                    cnt_d   = '0;
                    e_d     = 1'b1;
                end
            end
            S_EHIGH_LO: begin
                if (cnt_q == C_EHIGH_LAST) begin
                    state_d     = S_HOLD;
                    cnt_d       = '0;
                    e_d         = 1'b0;
                    data_d[3:0] = bus.iLCD_Data;
                end
            end
            S_HOLD: begin
                if (cnt_q == C_HOLD_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    rw_d    = 1'b0;
                    rel_d   = 1'b0;
                    rs_d    = 1'b0;
                    // Busy flag is only meaningful for an RS = 0 read; the
                    // full byte is already in data_q at this point.
                    busy_d  = ~rs_q & data_q[7];
                end
            end
            S_DONE: begin
                // DONE is the one idle cycle between reads: a pending start is
                // accepted here so a held start yields back-to-back reads.
                state_d = S_IDLE;
                cnt_d   = '0;
                if (bus.iStartRead) begin
                    state_d = S_SETUP;
                    rs_d    = bus.iRegisterSelect;
                    rw_d    = 1'b1;
                    rel_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.oLCD_Enabled        = e_q;
    assign bus.oLCD_ReadWrite      = rw_q;
    assign bus.oLCD_RegisterSelect = rs_q;
    assign bus.oBusRelease         = rel_q;
    assign bus.oData               = data_q;
    assign bus.oBusyFlag           = busy_q;
    assign bus.oReadDone           = done_q;

endmodule
`default_nettype wire
